cheshire_intr_cond: RTL and testbench
=====================================

Name: cheshire_intr_cond

Overview:
Interrupt conditioning stage directly upstream of the platform interrupt controller (PLIC).
- Consumes the flattened interrupt vector (ext, gpio, spi host, i2c, uart, zero) and produces clean, synchronous, level-type requests, one per PLIC source.
- Per source: input synchronisation, polarity adjust, and level or edge-latched mode.
- Edge-latched requests stay pending until the controller signals completion via ack.

Parameters:
NumSrc, 64, number of interrupt sources; equals PLIC NumSrc; bit 0 is the reserved zero source.
SyncStages, 2, synchroniser flops per source; legal range 0..3; 0 bypasses synchronisation.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
intr_i  input  NumSrc  raw interrupt sources, may be asynchronous
edge_mode_i  input  NumSrc  per-source mode; 1 = edge-latched, 0 = level; quasi-static config
active_low_i  input  NumSrc  per-source polarity; 1 inverts the source after synchronisation
ack_i  input  NumSrc  completion strobe from controller; 1-cycle pulse clears pending
intr_o  output  NumSrc  conditioned level requests to PLIC
pend_o  output  1  OR-reduction of intr_o, registered

Behaviour:
Reset (rst_i=1 at a rising edge) clears every flop: sync chain, prev, pending, intr_o=0, pend_o=0. Reset mid-operation drops all pending edges; nothing is replayed.

Per-source pipeline:
- s = intr_i after SyncStages flops.
- a = s XOR active_low_i (combinational).
- prev <= a every cycle.
- rise = a & ~prev.

Level mode:
- intr_o <= a.
- ack_i ignored.

Edge mode:
- pending <= rise | (pending & ~ack_i); intr_o = pending.
- Rise and ack in the same cycle: pending stays 1 (new event wins).
- Rise while already pending: absorbed, no second event.
- Ack with no pending: no effect.

Latency, from the first clock edge that samples intr_i high:
- intr_o high after SyncStages+1 edges in level mode and in edge mode (rise decoded off the last sync stage, pending registered).
- SyncStages=0: 1 edge.

Edge-mode deassert:
- A falling source does not clear pending; only ack_i does.
- intr_o falls 1 edge after the ack cycle.

Mode switch:
- Edge to level: pending cleared the same cycle; intr_o follows a from the next edge.
- Level to edge: pending starts 0; a source already high produces no event until a new rise.

Reset release with a source already asserted: prev=0, so a=1 yields one rise on the first cycle a is valid, i.e. one latched event.

Bit 0 is forced to 0 regardless of inputs: intr_o[0]=0, no flops used.

pend_o <= |intr_o, one edge after intr_o.

Widths: all vectors exactly NumSrc; no arithmetic in the base block.

Optional Feature:
Macro: CHESHIRE_INTR_COND_MISSCNT_EN

Defined:
- Adds output miss_cnt_o [NumSrc*8-1:0]: per-source 8-bit saturating counter of rises absorbed while pending (edge mode only).
- Counter increments on rise & pending & ~ack_i.
- Saturates at 8'hFF, no wrap.
- Cleared by reset or by ack_i for that source.
- Ack and an absorbed rise in the same cycle: counter cleared to 0 (ack wins).

Undefined:
- Port absent, no counter flops.
- Core behaviour identical in both builds.

Decomposition:
Shared package (cheshire_pkg):
- Enum intr_mode_e {IntrLevel=0, IntrEdge=1}.
- Constant IntrMissCntWidth=8.
- Default NumSrc derived from rv_plic_reg_pkg::NumSrc.

Sub-module cheshire_intr_cond_src holds the single-source slice: sync chain, prev, pending, optional counter. The top instantiates it NumSrc-1 times via generate and adds the pend_o register.

Test Plan:
1. SyncStages=2, src 5 level, intr_i[5] 0→1 at edge 0 → intr_o[5]=1 after edge 3; intr_i[5]→0 → intr_o[5]=0 three edges later; pend_o trails intr_o by 1 edge.
2. Src 9 edge mode, 1-cycle pulse on intr_i[9] → intr_o[9]=1 after edge 3 and held for 50 cycles with no ack; ack_i[9] pulse → intr_o[9]=0 next edge.
3. Src 9 edge mode: ack_i[9] in the same cycle as a new rise → intr_o[9] stays 1; a second ack on a quiet source → 0.
4. Src 12 active_low_i=1, intr_i[12] idle 1 then 0 → edge event latched; intr_i[0]=1 → intr_o[0] always 0.
5. rst_i asserted 1 cycle while srcs 3 and 7 pending → all outputs 0 next edge; src 7 held high through reset → exactly one event re-latched SyncStages+1 edges after release.
6. With CHESHIRE_INTR_COND_MISSCNT_EN: 300 rises on src 4 without ack → miss_cnt[4]=8'hFF; ack_i[4] → 0; undefined build → port absent, test 2 still passes.

Source files
------------

// File: rtl/cheshire_intr_cond_pkg.sv
// Shared types and constants for the interrupt conditioning stage.
package cheshire_intr_cond_pkg;

  typedef enum logic {
    IntrLevel = 1'b0,
    IntrEdge  = 1'b1
  } intr_mode_e;

  localparam int unsigned IntrMissCntWidth = 8;

  // Mirrors rv_plic_reg_pkg::NumSrc so that the conditioner and PLIC agree on width.
  localparam int unsigned NumSrcDefault = 64;

endpackage

// File: rtl/cheshire_intr_cond_src.sv
// Single interrupt source slice: synchroniser, polarity adjust, level/edge-latched request.
// Optional build macro CHESHIRE_INTR_COND_MISSCNT_EN adds a saturating count of absorbed rises.
module cheshire_intr_cond_src
  import cheshire_intr_cond_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic edge_mode,
  input  logic active_low,
  input  logic ack,
  output logic req
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
  ,
  output logic [IntrMissCntWidth-1:0] miss_cnt
`endif
);

  logic       s;
  logic       a;
  logic       rise;
  logic       prev_q;
  logic       pend_q;
  logic       pend_next;
  logic       req_q;
  intr_mode_e mode;

  if (SyncStages == 0) begin : g_nosync
    assign s = raw;
  end else begin : g_sync
    logic [SyncStages-1:0] sync_q;

    // Synchroniser chain; the last stage feeds the polarity/edge logic
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= raw;
        for (int k = 1; k < SyncStages; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign s = sync_q[SyncStages-1];
  end

  assign mode = intr_mode_e'(edge_mode);
  assign a    = s ^ active_low;
  assign rise = a & ~prev_q;

  // Pending only lives in edge mode; level mode keeps it cleared so a later switch starts clean
  always_comb begin
    pend_next = 1'b0;
    if (mode == IntrEdge) begin
      pend_next = rise | (pend_q & ~ack);
    end
  end

  // Previous-level tracker, pending latch and registered request
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      prev_q <= a;
      pend_q <= pend_next;
      req_q  <= (mode == IntrEdge) ? pend_next : a;
    end
  end

  assign req = req_q;

`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
  logic [IntrMissCntWidth-1:0] cnt_q;

  // Count rises swallowed by an already-pending request; ack clears and wins over a same-cycle rise
  always_ff @(posedge clk) begin
    if (rst || ack) begin
      cnt_q <= '0;
    end else if ((mode == IntrEdge) && rise && pend_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign miss_cnt = cnt_q;
`endif

endmodule

// File: rtl/cheshire_intr_cond.sv
// Interrupt conditioning ahead of the PLIC: one slice per source, source 0 tied low,
// plus a registered any-request flag.
// Optional build macro CHESHIRE_INTR_COND_MISSCNT_EN exposes per-source miss counters.
module cheshire_intr_cond
  import cheshire_intr_cond_pkg::*;
#(
  parameter int unsigned NumSrc     = NumSrcDefault,
  parameter int unsigned SyncStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumSrc-1:0] intr_i,
  input  logic [NumSrc-1:0] edge_mode_i,
  input  logic [NumSrc-1:0] active_low_i,
  input  logic [NumSrc-1:0] ack_i,
  output logic [NumSrc-1:0] intr_o,
  output logic              pend_o
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
  ,
  output logic [NumSrc*IntrMissCntWidth-1:0] miss_cnt_o
`endif
);

  logic pend_q;
  logic unused_src0;

  // Source 0 is the reserved zero source: no flops, inputs ignored
  assign intr_o[0]   = 1'b0;
  assign unused_src0 = ^{intr_i[0], edge_mode_i[0], active_low_i[0], ack_i[0]};
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
  assign miss_cnt_o[IntrMissCntWidth-1:0] = '0;
`endif

  for (genvar i = 1; i < NumSrc; i++) begin : g_src
    cheshire_intr_cond_src #(
      .SyncStages(SyncStages)
    ) u_src (
      .clk       (clk_i),
      .rst       (rst_i),
      .raw       (intr_i[i]),
      .edge_mode (edge_mode_i[i]),
      .active_low(active_low_i[i]),
      .ack       (ack_i[i]),
      .req       (intr_o[i])
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
      ,
      .miss_cnt  (miss_cnt_o[i*IntrMissCntWidth +: IntrMissCntWidth])
`endif
    );
  end

  // Any-request flag, one edge behind intr_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= |intr_o;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: tb/tb_cheshire_intr_cond.sv
// Scoreboard bench for cheshire_intr_cond: stimulus pushes model predictions, a negedge
// monitor pops and compares. Miss counters are checked when CHESHIRE_INTR_COND_MISSCNT_EN is set.
module tb_cheshire_intr_cond;

  localparam int N    = 64;
  localparam int S    = 2;
  localparam int MAXE = 4096;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] intr, em, al, ack;
  logic [N-1:0] intr_o;
  logic         pend_o;
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
  logic [N*8-1:0] miss_cnt_o;
`endif

  cheshire_intr_cond #(.NumSrc(N), .SyncStages(S)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .intr_i      (intr),
    .edge_mode_i (em),
    .active_low_i(al),
    .ack_i       (ack),
    .intr_o      (intr_o),
    .pend_o      (pend_o)
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
    ,
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           e;
    logic [N-1:0] io;
    logic         po;
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
    logic [N*8-1:0] mc;
`endif
  } exp_t;

  exp_t sb[$];

  // Reference model state: input histories per edge and per-source event bookkeeping
  logic [N-1:0] raw_h [MAXE];
  logic [N-1:0] a_h   [MAXE];
  bit           rst_h [MAXE];
  logic [N-1:0] pend_m   = '0;
  logic [N-1:0] out_prev = '0;
  int           cnt_m [N];

  // Predict the outputs seen after the upcoming edge from the inputs now being applied
  task automatic model_push();
    int           e;
    logic [N-1:0] s, a, prv, rise, outv;
    exp_t         x;
    e = edge_cnt + 1;
    if (e >= MAXE) begin
      $display("FAIL model_overflow edge=%0d limit=%0d", e, MAXE);
      $fatal(1);
    end
    raw_h[e] = intr;
    rst_h[e] = rst;
    // Conditioned level: raw value sampled S edges ago, zeroed if a reset landed since then
    if (S == 0) s = intr;
    else if (e - S < 1) s = '0;
    else begin
      s = raw_h[e-S];
      for (int k = e - S; k < e; k++) if (rst_h[k]) s = '0;
    end
    a = s ^ al;
    prv = (e > 1 && !rst_h[e-1]) ? a_h[e-1] : '0;
    a_h[e] = a;
    rise = a & ~prv;
    outv = '0;
    if (rst) begin
      pend_m = '0;
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
    end else begin
      for (int i = 1; i < N; i++) begin
        if (ack[i]) cnt_m[i] = 0;
        else if (em[i] && rise[i] && pend_m[i] && cnt_m[i] < 255) cnt_m[i] = cnt_m[i] + 1;
        if (em[i]) begin
          pend_m[i] = rise[i] | (pend_m[i] & ~ack[i]);
          outv[i]   = pend_m[i];
        end else begin
          pend_m[i] = 1'b0;
          outv[i]   = a[i];
        end
      end
    end
    x.e  = e;
    x.io = outv;
    x.po = rst ? 1'b0 : |out_prev;
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
    for (int i = 0; i < N; i++) x.mc[i*8 +: 8] = cnt_m[i][7:0];
`endif
    out_prev = outv;
    sb.push_back(x);
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle presents an output; compare the prediction tagged with this edge
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].e == edge_cnt) begin
      x = sb.pop_front();
      checks++;
      if (intr_o !== x.io) begin
        failures++;
        $display("FAIL intr_o edge=%0d got=%h exp=%h", x.e, intr_o, x.io);
      end
      checks++;
      if (pend_o !== x.po) begin
        failures++;
        $display("FAIL pend_o edge=%0d got=%b exp=%b", x.e, pend_o, x.po);
      end
`ifdef CHESHIRE_INTR_COND_MISSCNT_EN
      checks++;
      if (miss_cnt_o !== x.mc) begin
        failures++;
        $display("FAIL miss_cnt edge=%0d got=%h exp=%h", x.e, miss_cnt_o, x.mc);
      end
`endif
    end
  end

  initial begin
    for (int i = 0; i < N; i++) cnt_m[i] = 0;
    rst = 1'b1; intr = '0; em = '0; al = '0; ack = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();

    // Level source 5 rise and fall, reserved source 0 driven high
    intr[0] = 1'b1;
    intr[5] = 1'b1; repeat (6) tick();
    intr[5] = 1'b0; repeat (6) tick();

    // Edge source 9: single pulse held 50 cycles, then ack
    em[9] = 1'b1; repeat (2) tick();
    intr[9] = 1'b1; tick();
    intr[9] = 1'b0; repeat (50) tick();
    ack[9] = 1'b1; tick();
    ack[9] = 1'b0; repeat (3) tick();

    // Edge source 9: new rise coincides with ack, then a quiet ack
    intr[9] = 1'b1; tick();
    intr[9] = 1'b0; repeat (4) tick();
    intr[9] = 1'b1; tick();
    intr[9] = 1'b0; tick();
    ack[9] = 1'b1; tick();
    ack[9] = 1'b0; repeat (3) tick();
    ack[9] = 1'b1; tick();
    ack[9] = 1'b0; repeat (3) tick();
    ack[9] = 1'b1; tick();
    ack[9] = 1'b0; repeat (3) tick();

    // Active-low edge source 12: idle high, then asserted low
    em[12] = 1'b1; al[12] = 1'b1; intr[12] = 1'b1; repeat (5) tick();
    ack[12] = 1'b1; tick();
    ack[12] = 1'b0; repeat (2) tick();
    intr[12] = 1'b0; repeat (5) tick();

    // Reset while sources 3 and 7 pending; 7 stays high through reset
    em[3] = 1'b1; em[7] = 1'b1;
    intr[3] = 1'b1; intr[7] = 1'b1; tick();
    intr[3] = 1'b0; repeat (5) tick();
    rst = 1'b1; tick();
    rst = 1'b0; repeat (6) tick();

    // Mode switches with source 7 still high
    em[7] = 1'b0; repeat (3) tick();
    em[7] = 1'b1; repeat (3) tick();
    intr[7] = 1'b0; repeat (3) tick();
    intr[7] = 1'b1; repeat (4) tick();
    em[7] = 1'b0; repeat (3) tick();

    // Source 4 edge mode: 300 rises without ack, then ack
    em[4] = 1'b1;
    for (int r = 0; r < 300; r++) begin
      intr[4] = 1'b1; tick();
      intr[4] = 1'b0; tick();
    end
    repeat (3) tick();
    ack[4] = 1'b1; tick();
    ack[4] = 1'b0; repeat (3) tick();

    // Randomised traffic
    for (int t = 0; t < 1500; t++) begin
      intr = intr ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      ack  = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (t % 100 == 0) em = {$urandom, $urandom};
      if (t % 300 == 0) al = {$urandom, $urandom};
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; ack = '0;
    repeat (3) tick();

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending entries exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
